// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared encodings for the control-transfer sequencer.
// Op kinds, branch funct3 values and FSM states.
package branch_redirect_ctrl_pkg;

    localparam logic [1:0] KIND_BR   = 2'b00;
    localparam logic [1:0] KIND_JAL  = 2'b01;
    localparam logic [1:0] KIND_JALR = 2'b10;
    localparam logic [1:0] KIND_RSV  = 2'b11;

    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EVAL,
        S_FLUSH,
        S_TRAP
    } state_t;

    function automatic logic is_legal_br(input logic [2:0] sel);
        return !((sel == 3'b010) || (sel == 3'b011));
    endfunction

endpackage

// File: rtl/branch_redirect_ctrl_cmp.sv
// Shared branch comparator: funct3-selected compare of rs1/rs2.
// Encodings 010/011 never report taken.
module branch_redirect_ctrl_cmp
    import branch_redirect_ctrl_pkg::*;
(
    input  logic [31:0] i_rs1,
    input  logic [31:0] i_rs2,
    input  logic [2:0]  i_sel,
    output logic        o_taken
);

    logic w_eq;
    logic w_lt;
    logic w_ltu;

    assign w_eq  = (i_rs1 == i_rs2);
    assign w_lt  = ($signed(i_rs1) < $signed(i_rs2));
    assign w_ltu = (i_rs1 < i_rs2);

    always_comb begin
        o_taken = 1'b0;
        case (i_sel)
            BR_BEQ:  o_taken = w_eq;
            BR_BNE:  o_taken = !w_eq;
            BR_BLT:  o_taken = w_lt;
            BR_BGE:  o_taken = !w_lt;
            BR_BLTU: o_taken = w_ltu;
            BR_BGEU: o_taken = !w_ltu;
            default: o_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Control-transfer sequencer: accepts one branch/JAL/JALR op, then
// issues a redirect with link and flush, or a misaligned-target trap.
module branch_redirect_ctrl
    import branch_redirect_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic [1:0]       i_req_kind,
    input  logic [2:0]       i_req_br_sel,
    input  logic [31:0]      i_req_pc,
    input  logic [31:0]      i_req_rs1,
    input  logic [31:0]      i_req_rs2,
    input  logic [31:0]      i_req_imm,
    output logic             o_redirect_valid,
    output logic [31:0]      o_redirect_pc,
    output logic             o_link_valid,
    output logic [31:0]      o_link_data,
    output logic             o_flush,
    output logic             o_misalign_trap,
    output logic [31:0]      o_trap_pc,
    input  logic             i_trap_ack,
    output logic             o_illegal_sel,
    output logic [CNT_W-1:0] o_taken_count
);

    localparam logic [3:0] FCNT_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t r_state;
    state_t w_next;

    logic [1:0]       r_kind;
    logic [2:0]       r_sel;
    logic [31:0]      r_pc;
    logic [31:0]      r_rs1;
    logic [31:0]      r_rs2;
    logic [31:0]      r_imm;
    logic [3:0]       r_fcnt;
    logic             r_redir_v;
    logic [31:0]      r_redir_pc;
    logic             r_link_v;
    logic [31:0]      r_link_data;
    logic             r_flush;
    logic             r_trap;
    logic [31:0]      r_trap_pc;
    logic             r_ill;
    logic [CNT_W-1:0] r_cnt;

    logic        w_accept;
    logic        w_eval;
    logic        w_br_taken;
    logic        w_taken;
    logic [31:0] w_target;
    logic        w_misalign;
    logic        w_redir;
    logic        w_illegal;

    branch_redirect_ctrl_cmp u_cmp (
        .i_rs1   (r_rs1),
        .i_rs2   (r_rs2),
        .i_sel   (r_sel),
        .o_taken (w_br_taken)
    );

    assign o_req_ready = (r_state == S_IDLE);
    assign w_accept    = i_req_valid && o_req_ready;
    assign w_eval      = (r_state == S_EVAL);

    always_comb begin
        w_taken = 1'b0;
        case (r_kind)
            KIND_BR:   w_taken = w_br_taken;
            KIND_JAL:  w_taken = 1'b1;
            KIND_JALR: w_taken = 1'b1;
            default:   w_taken = 1'b0;
        endcase
    end

    // JALR clears bit 0 of its target; bit 1 alone decides misalignment
    assign w_target   = (r_kind == KIND_JALR) ?
                        ((r_rs1 + r_imm) & ~32'h1) : (r_pc + r_imm);
    assign w_misalign = w_taken && w_target[1];
    assign w_redir    = w_eval && w_taken && !w_target[1];
    assign w_illegal  = (r_kind == KIND_RSV) ||
                        ((r_kind == KIND_BR) && !is_legal_br(r_sel));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_req_valid) w_next = S_EVAL;
            end
            S_EVAL: begin
                if (!w_taken)       w_next = S_IDLE;
                else if (w_misalign) w_next = S_TRAP;
                else                w_next = S_FLUSH;
            end
            S_FLUSH: begin
                if (r_fcnt == 4'd0) w_next = S_IDLE;
            end
            S_TRAP: begin
                if (i_trap_ack) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_kind <= KIND_BR;
            r_sel  <= BR_BEQ;
            r_pc   <= '0;
            r_rs1  <= '0;
            r_rs2  <= '0;
            r_imm  <= '0;
        end else if (w_accept) begin
            r_kind <= i_req_kind;
            r_sel  <= i_req_br_sel;
            r_pc   <= i_req_pc;
            r_rs1  <= i_req_rs1;
            r_rs2  <= i_req_rs2;
            r_imm  <= i_req_imm;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fcnt      <= '0;
            r_redir_v   <= 1'b0;
            r_redir_pc  <= '0;
            r_link_v    <= 1'b0;
            r_link_data <= '0;
            r_flush     <= 1'b0;
            r_trap      <= 1'b0;
            r_trap_pc   <= '0;
            r_ill       <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_redir_v <= w_redir;
            r_link_v  <= w_redir && (r_kind != KIND_BR);
            r_flush   <= (w_next == S_FLUSH);
            r_trap    <= (w_next == S_TRAP);
            r_ill     <= w_eval && w_illegal;
            if (w_redir) begin
                r_redir_pc  <= w_target;
                r_link_data <= r_pc + 32'd4;
                r_cnt       <= r_cnt + 1'b1;
                r_fcnt      <= FCNT_LOAD;
            end else if ((r_state == S_FLUSH) && (r_fcnt != 4'd0)) begin
                r_fcnt <= r_fcnt - 4'd1;
            end
            if (w_eval && w_misalign) begin
                r_trap_pc <= w_target;
            end
        end
    end

    assign o_redirect_valid = r_redir_v;
    assign o_redirect_pc    = r_redir_pc;
    assign o_link_valid     = r_link_v;
    assign o_link_data      = r_link_data;
    assign o_flush          = r_flush;
    assign o_misalign_trap  = r_trap;
    assign o_trap_pc        = r_trap_pc;
    assign o_illegal_sel    = r_ill;
    assign o_taken_count    = r_cnt;

endmodule
